// File: rtl/sine_pkg.sv
// Shared definitions for the sine NCO: controller states, output scaling
// constants and the quarter-wave table generator.
package sine_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } nco_state_t;

  localparam int MIDSCALE = 2048;
  localparam int AMPL     = 2047;

  // Entry idx of a quarter-wave table with 2**addr_w points, sampled at the
  // centre of each address bin so that the mirrored quadrants stay symmetric.
  function automatic int rom_value(input int idx, input int addr_w);
    real pi;
    real x;
    pi = 3.14159265358979323846;
    x  = (real'(idx) + 0.5) * pi / real'(1 << (addr_w + 1));
    return $rtoi(real'(AMPL) * $sin(x) + 0.5);
  endfunction

endpackage

// File: rtl/sine_nco_if.sv
// Control and sample bus between the NCO and its host / DAC side.
interface sine_nco_if #(
  parameter int PHASE_W = 16,
  parameter int DIV_W   = 16,
  parameter int DATA_W  = 12
);
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] ftw;
  logic [DIV_W-1:0]   div;
  logic [DATA_W-1:0]  I_data;
  logic               en;
  logic               busy;

  modport master (output start, stop, ftw, div, input I_data, en, busy);
  modport slave  (input start, stop, ftw, div, output I_data, en, busy);
endinterface

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude table with a registered read port.
module sine_quarter_rom
  import sine_pkg::*;
#(
  parameter int LUT_ADDR_W = 8,
  parameter int DATA_W     = 12
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [DATA_W-2:0]     data
);

  localparam int DEPTH = 1 << LUT_ADDR_W;

  logic [DATA_W-2:0] table_w [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam int V = rom_value(g, LUT_ADDR_W);
    assign table_w[g] = V[DATA_W-2:0];
  end

  // Registered read; the enable keeps the last magnitude between samples.
  always_ff @(posedge clk) begin
    if (rd_en) data <= table_w[addr];
  end

endmodule

// File: rtl/sine_nco.sv
// Numerically controlled sine source feeding the 12-bit DAC. A phase
// accumulator steps by a tuning word on every divider tick; the phase is
// folded onto a quarter-wave table and unfolded back to offset binary.
module sine_nco
  import sine_pkg::*;
#(
  parameter int PHASE_W    = 16,
  parameter int LUT_ADDR_W = 8,
  parameter int DATA_W     = 12,
  parameter int DIV_W      = 16
) (
  input  logic     clk,
  input  logic     rst,
  sine_nco_if.slave bus
);

  nco_state_t          state;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  ftw_act;
  logic [DIV_W-1:0]    cnt;
  logic [DIV_W-1:0]    div_act;
  logic [PHASE_W:0]    phase_sum;
  logic                tick;
  logic                wrap;
  logic                done;

  logic [1:0]            q_p0;
  logic [LUT_ADDR_W-1:0] k_p0;
  logic [LUT_ADDR_W-1:0] addr_p0;
  logic                  vld_p1;
  logic                  neg_p1;
  logic [DATA_W-2:0]     m_p1;
  logic                  park_p0;
  logic                  park_p1;
  logic                  park_p2;
  logic                  vld_p2;
  logic [DATA_W-1:0]     data_p2;

  // Offset-binary unfold: upper half-cycle adds the magnitude, lower half
  // subtracts it. The table peak is AMPL, so the result never leaves 1..4095.
  function automatic logic [DATA_W-1:0] to_offset(input logic neg,
                                                  input logic [DATA_W-2:0] m);
    logic signed [DATA_W:0] mid_s;
    logic signed [DATA_W:0] m_s;
    logic signed [DATA_W:0] acc;
    mid_s = (DATA_W+1)'(MIDSCALE);
    m_s   = signed'({2'b00, m});
    acc   = neg ? (mid_s - m_s) : (mid_s + m_s);
    return DATA_W'(acc);
  endfunction

  assign tick      = (state != IDLE) && (cnt == div_act);
  assign phase_sum = {1'b0, phase} + {1'b0, ftw_act};
  assign wrap      = phase_sum[PHASE_W];
  assign done      = tick && (state == STOPPING) && (wrap || (ftw_act == '0));

  // Controller: start capture, divider, phase accumulation and stop-at-wrap.
  // A start is held off for the one cycle where it would collide in the
  // output stage with the trailing midscale pulse of the previous stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      cnt     <= '0;
      ftw_act <= '0;
      div_act <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop && !park_p0) begin
            state   <= RUN;
            ftw_act <= bus.ftw;
            div_act <= bus.div;
            phase   <= '0;
            cnt     <= '0;
          end
        end
        RUN: begin
          if (bus.stop) state <= STOPPING;
          if (tick) begin
            cnt   <= '0;
            phase <= phase_sum[PHASE_W-1:0];
            if (wrap && !bus.stop) ftw_act <= bus.ftw;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        STOPPING: begin
          if (tick) begin
            cnt <= '0;
            if (done) begin
              state <= IDLE;
              phase <= '0;
            end else begin
              phase <= phase_sum[PHASE_W-1:0];
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage 0: quadrant fold of the current phase into a table address
  assign q_p0    = phase[PHASE_W-1 -: 2];
  assign k_p0    = phase[PHASE_W-3 -: LUT_ADDR_W];
  assign addr_p0 = q_p0[0] ? ~k_p0 : k_p0;

  // ---- stage 1: table read registered inside the ROM, sign bit alongside
  sine_quarter_rom #(
    .LUT_ADDR_W (LUT_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_rom (
    .clk   (clk),
    .rd_en (tick),
    .addr  (addr_p0),
    .data  (m_p1)
  );

  // Half-cycle sign travels with the table read.
  always_ff @(posedge clk) begin
    if (tick) neg_p1 <= q_p0[1];
  end

  // Sample valid and the delayed midscale-park request after a stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      park_p0 <= 1'b0;
      park_p1 <= 1'b0;
      park_p2 <= 1'b0;
    end else begin
      vld_p1  <= tick;
      park_p0 <= done;
      park_p1 <= park_p0;
      park_p2 <= park_p1;
    end
  end

  // ---- stage 2: offset-binary output register and DAC strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p2 <= DATA_W'(MIDSCALE);
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1 | park_p2;
      if (park_p2)     data_p2 <= DATA_W'(MIDSCALE);
      else if (vld_p1) data_p2 <= to_offset(neg_p1, m_p1);
    end
  end

  assign bus.I_data = data_p2;
  assign bus.en     = vld_p2;
  assign bus.busy   = (state != IDLE);

endmodule

// File: doc/sine_nco.md
Name: sine_nco

Overview:
- Numerically controlled sine source for the sine-wave project; sits directly upstream of the 12-bit DAC model.
- Drives the DAC's 12-bit data input and enable strobe from `I_data` and `en`.
- Phase accumulator with a programmable tuning word, a quarter-wave ROM and a programmable sample-rate divider.
- Start/stop control that always stops at a phase-zero boundary and parks the output at midscale.

Parameters:
- PHASE_W, 16, phase accumulator width.
- LUT_ADDR_W, 8, quarter-wave ROM address width (256 entries).
- DATA_W, 12, sample width, offset binary (matches the DAC input).
- DIV_W, 16, sample-rate divider width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each clk; begins generation.
- stop  in  1  level, sampled each clk; requests a stop at the next phase wrap.
- ftw  in  PHASE_W  frequency tuning word; phase increment per sample.
- div  in  DIV_W  sample period minus one, in clk cycles.
- I_data  out  DATA_W  sample to the DAC.
- en  out  1  one-clk pulse; I_data was updated this cycle.
- busy  out  1  high in RUN or STOPPING.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, phase=0, divider count=0.
  - I_data=2048 (midscale), en=0, busy=0.
  - Pipeline contents are discarded.
- FSM states: IDLE, RUN, STOPPING.
- IDLE:
  - start=1 and stop=0 → RUN; capture ftw into ftw_act and div into div_act; clear phase and divider count.
  - start=1 and stop=1 → stay in IDLE.
- Sample tick:
  - In RUN or STOPPING, the divider counts 0..div_act.
  - tick=1 when count==div_act, then the count reloads to 0.
  - div_act=0 gives a tick every clk.
- On each tick:
  - The current phase is presented to the lookup pipeline.
  - The phase updates as phase+ftw_act, modulo 2^PHASE_W.
  - wrap = carry out of that add.
  - The first sample after start uses phase 0.
- Lookup pipeline (fixed latency of 2 clk from tick to en):
  - Stage 1 (registered):
    - quadrant q = phase[PHASE_W-1:PHASE_W-2].
    - k = phase[PHASE_W-3 -: LUT_ADDR_W].
    - Address = k for q=0 or 2; address = ~k for q=1 or 3.
  - Stage 2 (registered):
    - m = ROM[address].
    - I_data = 2048+m for q=0 or 1; I_data = 2048-m for q=2 or 3.
    - en=1 for this one cycle.
- ROM contents:
  - ROM[i] = round(2047*sin((i+0.5)*pi/512)), unsigned 11-bit.
  - ROM[0]=6, ROM[255]=2047.
  - Output range is 1..4095; 0 is never produced.
- ftw updates:
  - In RUN, when a tick produces wrap=1, ftw_act is reloaded from ftw, so frequency changes only at cycle boundaries.
  - div changes take effect only at start.
- start while in RUN or STOPPING: ignored.
- RUN + stop=1 → STOPPING (stop has priority over everything in RUN).
- STOPPING:
  - Ticks continue.
  - Exit on the first tick with wrap=1, or on the first tick if ftw_act==0.
  - That tick still produces its sample normally.
  - Then state=IDLE and phase=0.
  - Two clk after the last sample's en, one extra en pulse occurs with I_data=2048.
  - busy falls when the state enters IDLE; the trailing pipeline pulses still complete.
- Idle output: I_data holds its last value; en=0.
- Arithmetic:
  - Phase add is unsigned and wraps silently.
  - The 2048±m computation is done at DATA_W+1 bits; saturation is not needed by construction.

Decomposition:
- Shared package `sine_pkg` holds:
  - the FSM state enum `nco_state_t` (IDLE, RUN, STOPPING);
  - the constants MIDSCALE=2048 and AMPL=2047;
  - the ROM init function that builds the quarter-wave table from the formula above.
- One sub-module, `sine_quarter_rom`:
  - synchronous read, LUT_ADDR_W address, DATA_W-1 data;
  - contents supplied by the package function.

Test Plan:
1. Reset mid-RUN: assert rst asynchronously between clk edges → I_data=2048, en=0 and busy=0 immediately; no en pulses until the next start.
2. div=3, ftw=0x4000, start pulse:
   - en pulses every 4 clk, the first 2 clk after the first tick.
   - I_data sequence is 2054, 4095, 2042, 1, then repeats.
3. div=0, ftw=0x0040:
   - en asserted every clk after 2-clk fill.
   - The samples increase monotonically through the first quadrant.
   - I_data 4095 is first reached at sample index 255.
4. Frequency change: in RUN with ftw=0x4000, change ftw to 0x2000 mid-cycle → the old step is kept until the sample that follows the wrap, then 8 samples per cycle.
5. Stop: ftw=0x4000, stop asserted after sample 4095 → samples 2042 and 1 are emitted, then one en with I_data=2048; busy=0; a subsequent start restarts at 2054.
6. Corner cases:
   - start and stop together in IDLE → stays IDLE.
   - ftw=0 run then stop → constant 2054 samples, exit on the first tick after stop, followed by a 2048 pulse.
